// File: rtl/tinyrv1_mem_arbiter.sv
// Single-port memory arbiter for TinyRV1 fetch and data ports: data priority, fetch starvation guard.
// Optional performance counters enabled by defining TINYRV1_MEM_ARB_PERF_EN.
module tinyrv1_mem_arbiter #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imemreq_val,
  output logic          imemreq_rdy,
  input  logic [31:0]   imemreq_addr,
  output logic          imemresp_val,
  output logic [31:0]   imemresp_data,
  input  logic          dmemreq_val,
  output logic          dmemreq_rdy,
  input  logic          dmemreq_type,
  input  logic [31:0]   dmemreq_addr,
  input  logic [31:0]   dmemreq_wdata,
  output logic          dmemresp_val,
  output logic [31:0]   dmemresp_rdata,
  output logic          memreq_val,
  output logic          memreq_type,
  output logic [AW-1:0] memreq_addr,
  output logic [31:0]   memreq_wdata,
  input  logic [31:0]   memresp_rdata
`ifdef TINYRV1_MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_igrants,
  output logic [31:0]   perf_dgrants,
  output logic [31:0]   perf_conflicts
`endif
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_I    = 2'd1,
    PEND_D_RD = 2'd2,
    PEND_D_WR = 2'd3
  } pend_e;

  pend_e       pend_r;
  pend_e       pend_next_s;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_cnt_next_s;
  logic [31:0] idata_hold_r;
  logic [31:0] ddata_hold_r;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        i_acc_s;
  logic        d_acc_s;

  // Grant selection: data wins conflicts unless fetch has lost STARVE_MAX in a row
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (!rst) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (imemreq_val && dmemreq_val) begin
      if (starve_cnt_r == STARVE_MAX_C) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
    end else if (imemreq_val) begin
      grant_i_s = 1'b1;
    end else if (dmemreq_val) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  assign imemreq_rdy = grant_i_s;
  assign dmemreq_rdy = grant_d_s;
  assign i_acc_s     = imemreq_val && grant_i_s;
  assign d_acc_s     = dmemreq_val && grant_d_s;

  // Memory request mux; upper address bits are dropped so indexing wraps
  always_comb begin
    memreq_val   = 1'b0;
    memreq_type  = 1'b0;
    memreq_addr  = '0;
    memreq_wdata = 32'd0;
    if (grant_i_s) begin
      memreq_val  = 1'b1;
      memreq_addr = imemreq_addr[AW-1:0];
    end else if (grant_d_s) begin
      memreq_val   = 1'b1;
      memreq_type  = dmemreq_type;
      memreq_addr  = dmemreq_addr[AW-1:0];
      memreq_wdata = dmemreq_wdata;
    end else begin
      memreq_val = 1'b0;
    end
  end

  // Next pending-response state and saturating starvation count
  always_comb begin
    pend_next_s       = PEND_NONE;
    starve_cnt_next_s = starve_cnt_r;
    if (i_acc_s) begin
      pend_next_s = PEND_I;
    end else if (d_acc_s) begin
      pend_next_s = dmemreq_type ? PEND_D_WR : PEND_D_RD;
    end else begin
      pend_next_s = PEND_NONE;
    end
    if (!imemreq_val || i_acc_s) begin
      starve_cnt_next_s = 4'd0;
    end else if (d_acc_s) begin
      starve_cnt_next_s = (starve_cnt_r >= STARVE_MAX_C) ? STARVE_MAX_C : starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Pending-response and starvation state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r       <= PEND_NONE;
      starve_cnt_r <= 4'd0;
    end else begin
      pend_r       <= pend_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Hold the last delivered response data for idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idata_hold_r <= 32'd0;
      ddata_hold_r <= 32'd0;
    end else begin
      idata_hold_r <= imemresp_data;
      ddata_hold_r <= dmemresp_rdata;
    end
  end

  // Response steering from the pending state
  always_comb begin
    imemresp_val   = 1'b0;
    imemresp_data  = idata_hold_r;
    dmemresp_val   = 1'b0;
    dmemresp_rdata = ddata_hold_r;
    case (pend_r)
      PEND_I: begin
        imemresp_val  = 1'b1;
        imemresp_data = memresp_rdata;
      end
      PEND_D_RD: begin
        dmemresp_val   = 1'b1;
        dmemresp_rdata = memresp_rdata;
      end
      PEND_D_WR: begin
        dmemresp_val   = 1'b1;
        dmemresp_rdata = 32'd0;
      end
      default: begin
        imemresp_val = 1'b0;
        dmemresp_val = 1'b0;
      end
    endcase
  end

`ifdef TINYRV1_MEM_ARB_PERF_EN
  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_igrants   <= 32'd0;
      perf_dgrants   <= 32'd0;
      perf_conflicts <= 32'd0;
    end else begin
      perf_igrants   <= perf_igrants + {31'd0, i_acc_s};
      perf_dgrants   <= perf_dgrants + {31'd0, d_acc_s};
      perf_conflicts <= perf_conflicts + {31'd0, (imemreq_val && dmemreq_val)};
    end
  end
`endif

endmodule

// File: tb/tb_tinyrv1_mem_arbiter.sv
// Directed bench for tinyrv1_mem_arbiter with a behavioural synchronous-read memory.
module tb_tinyrv1_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_rdy;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemresp_val;
  logic [31:0] dmemresp_rdata;
  logic        memreq_val;
  logic        memreq_type;
  logic [13:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic [31:0] memresp_rdata;

  int n_cmp;
  int n_bad;

  tinyrv1_mem_arbiter #(.AW(14), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
    .memreq_val(memreq_val), .memreq_type(memreq_type), .memreq_addr(memreq_addr),
    .memreq_wdata(memreq_wdata), .memresp_rdata(memresp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port memory; preloaded on the first edge
  logic [31:0] mem [0:16383];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'd0;
      mem[14'h0010] <= 32'hDEADBEEF;
      memresp_rdata <= 32'd0;
    end else if (memreq_val) begin
      if (memreq_type) mem[memreq_addr] <= memreq_wdata;
      else             memresp_rdata   <= mem[memreq_addr];
    end
  end

  typedef struct {
    logic        ival;  logic [31:0] iaddr;
    logic        dval;  logic dtype; logic [31:0] daddr; logic [31:0] dwdata;
    logic        irdy;  logic drdy;  logic mval; logic mtype; logic [13:0] maddr; logic [31:0] mwdata;
    logic        iresp; logic [31:0] idata;
    logic        dresp; logic [31:0] ddata;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dt,
                       input logic [31:0] da, input logic [31:0] dw);
    imemreq_val   = iv;
    imemreq_addr  = ia;
    dmemreq_val   = dv;
    dmemreq_type  = dt;
    dmemreq_addr  = da;
    dmemreq_wdata = dw;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //          ival iaddr          dval dt daddr          dwdata         irdy drdy mv mt maddr     mwdata         ir idata          dr ddata
    vecs[0]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 14'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h20,       32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 14'h20,   32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 14'h20,   32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678};
    vecs[3]  = '{1'b1, 32'h00004010, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 14'h10,   32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h12345678};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h12345678};
    vecs[5]  = '{1'b1, 32'h30,       1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 14'h10,   32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 32'h30,       1'b1, 1'b1, 32'h30,       32'h11112222, 1'b0, 1'b1, 1'b1, 1'b1, 14'h30,   32'h11112222, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h30,       1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 14'h30,   32'h0,        1'b1, 32'h11112222, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b1, 14'h3FFF, 32'hA5A5A5A5, 1'b0, 32'h11112222, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h00007FFF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 14'h3FFF, 32'h0,        1'b0, 32'h11112222, 1'b1, 32'hA5A5A5A5};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 14'h0,    32'h0,        1'b0, 32'h11112222, 1'b0, 32'hA5A5A5A5};

    // Reset held with both requesters valid: nothing granted, nothing returned
    rst      = 1'b0;
    mem_init = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("rst_irdy", 0, {31'd0, imemreq_rdy}, 32'd0);
    chk("rst_drdy", 0, {31'd0, dmemreq_rdy}, 32'd0);
    chk("rst_mval", 0, {31'd0, memreq_val}, 32'd0);
    chk("rst_iresp", 0, {31'd0, imemresp_val}, 32'd0);
    chk("rst_dresp", 0, {31'd0, dmemresp_val}, 32'd0);
    chk("rst_idata", 0, imemresp_data, 32'd0);
    chk("rst_ddata", 0, dmemresp_rdata, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_drdy", 0, {31'd0, dmemreq_rdy}, 32'd1);
    chk("rel_irdy", 0, {31'd0, imemreq_rdy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_dresp", 0, {31'd0, dmemresp_val}, 32'd1);
    chk("rel_ddata", 0, dmemresp_rdata, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Table-driven single-cycle vectors, each checked on request and response cycles
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(vecs[v].ival, vecs[v].iaddr, vecs[v].dval, vecs[v].dtype, vecs[v].daddr, vecs[v].dwdata);
      #1;
      chk("irdy", v, {31'd0, imemreq_rdy}, {31'd0, vecs[v].irdy});
      chk("drdy", v, {31'd0, dmemreq_rdy}, {31'd0, vecs[v].drdy});
      chk("mval", v, {31'd0, memreq_val}, {31'd0, vecs[v].mval});
      if (vecs[v].mval) begin
        chk("mtype", v, {31'd0, memreq_type}, {31'd0, vecs[v].mtype});
        chk("maddr", v, {18'd0, memreq_addr}, {18'd0, vecs[v].maddr});
        if (vecs[v].mtype) chk("mwdata", v, memreq_wdata, vecs[v].mwdata);
      end
      @(posedge clk);
      #1;
      chk("iresp", v, {31'd0, imemresp_val}, {31'd0, vecs[v].iresp});
      chk("idata", v, imemresp_data, vecs[v].idata);
      chk("dresp", v, {31'd0, dmemresp_val}, {31'd0, vecs[v].dresp});
      chk("ddata", v, dmemresp_rdata, vecs[v].ddata);
    end

    // Starvation: both held valid, fetch wins every fifth cycle with count at its limit
    @(negedge clk);
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = (k == 4) || (k == 9);
      #1;
      chk("stv_irdy", k, {31'd0, imemreq_rdy}, {31'd0, exp_i});
      chk("stv_drdy", k, {31'd0, dmemreq_rdy}, {31'd0, ~exp_i});
      if (exp_i) chk("stv_cnt", k, {28'd0, dut.starve_cnt_r}, 32'd4);
      @(posedge clk);
      #1;
      if (exp_i) begin
        chk("stv_iresp", k, {31'd0, imemresp_val}, 32'd1);
        chk("stv_idata", k, imemresp_data, 32'hDEADBEEF);
      end else begin
        chk("stv_dresp", k, {31'd0, dmemresp_val}, 32'd1);
        chk("stv_ddata", k, dmemresp_rdata, 32'h12345678);
      end
      @(negedge clk);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset during the response cycle of an accepted fetch drops that response
    @(negedge clk);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mf_irdy", 0, {31'd0, imemreq_rdy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mf_iresp_rst", 0, {31'd0, imemresp_val}, 32'd0);
    chk("mf_idata_rst", 0, imemresp_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("mf_iresp", k, {31'd0, imemresp_val}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
